// File: rtl/fft_pkg.sv
// Shared constants, complex sample type and bit-reversal helper for the FFT bit-reversal streamer.
// Optional bin index output is enabled with FFT_BIN_IDX_EN (see fft_bitrev_streamer).
package fft_pkg;

    localparam int unsigned POINT_FFT_POW2_DFLT = 4;
    localparam int unsigned FRAC_BITS_DFLT      = 15;
    localparam int unsigned DW_DFLT             = FRAC_BITS_DFLT + POINT_FFT_POW2_DFLT + 1;

    typedef struct packed {
        logic signed [DW_DFLT-1:0] re;
        logic signed [DW_DFLT-1:0] im;
    } cplx_t;

    // Reverses the low w bits of v; bits above w are dropped.
    function automatic int unsigned bitrev(input int unsigned v, input int unsigned w);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < w; i++) begin
            r = r | (((v >> i) & 32'd1) << (w - 1 - i));
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_streamer_if.sv
// Frame-in / bin-out handshake bundle of the FFT bit-reversal streamer.
// bin_idx_o exists only when FFT_BIN_IDX_EN is defined.
interface fft_bitrev_streamer_if
    import fft_pkg::*;
#(
    parameter int unsigned POINT_FFT_POW2 = POINT_FFT_POW2_DFLT,
    parameter int unsigned FRAC_BITS      = FRAC_BITS_DFLT
);
    localparam int unsigned POINT_FFT = 1 << POINT_FFT_POW2;
    localparam int unsigned DW        = FRAC_BITS + POINT_FFT_POW2 + 1;

    logic signed [DW-1:0] frame_i [2][POINT_FFT];
    logic                 frame_valid_i;
    logic                 frame_ready_o;
    logic signed [DW-1:0] bin_re_o;
    logic signed [DW-1:0] bin_im_o;
    logic                 bin_valid_o;
    logic                 bin_ready_i;
    logic                 bin_last_o;
`ifdef FFT_BIN_IDX_EN
    logic [POINT_FFT_POW2-1:0] bin_idx_o;
`endif

    // Streamer side.
    modport slave (
        input  frame_i, frame_valid_i, bin_ready_i,
`ifdef FFT_BIN_IDX_EN
        output bin_idx_o,
`endif
        output frame_ready_o, bin_re_o, bin_im_o, bin_valid_o, bin_last_o
    );

    // Upstream FFT core plus downstream consumer side.
    modport master (
        output frame_i, frame_valid_i, bin_ready_i,
`ifdef FFT_BIN_IDX_EN
        input  bin_idx_o,
`endif
        input  frame_ready_o, bin_re_o, bin_im_o, bin_valid_o, bin_last_o
    );

endinterface

// File: rtl/fft_frame_bank.sv
// One frame bank: parallel write of a whole complex frame, single indexed combinational read.
// Unaffected by FFT_BIN_IDX_EN.
module fft_frame_bank #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 20
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic signed [DW-1:0] wr_re_i [2**AW],
    input  logic signed [DW-1:0] wr_im_i [2**AW],
    input  logic [AW-1:0]        rd_addr_i,
    output logic signed [DW-1:0] rd_re_o,
    output logic signed [DW-1:0] rd_im_o
);

    logic signed [DW-1:0] mem_re [2**AW];
    logic signed [DW-1:0] mem_im [2**AW];

    // Contents need no reset: the owner's full flag gates every read.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_re <= wr_re_i;
            mem_im <= wr_im_i;
        end
    end

    always_comb begin
        rd_re_o = mem_re[rd_addr_i];
        rd_im_o = mem_im[rd_addr_i];
    end

endmodule

// File: rtl/fft_bitrev_streamer.sv
// Ping-pong buffer that captures bit-reversed FFT frames and streams bins out in natural order.
// Define FFT_BIN_IDX_EN to add the bin_idx_o output.
module fft_bitrev_streamer
    import fft_pkg::*;
#(
    parameter int unsigned POINT_FFT_POW2 = POINT_FFT_POW2_DFLT,
    parameter int unsigned FRAC_BITS      = FRAC_BITS_DFLT
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    fft_bitrev_streamer_if.slave  bus
);

    localparam int unsigned POINT_FFT = 1 << POINT_FFT_POW2;
    localparam int unsigned DW        = FRAC_BITS + POINT_FFT_POW2 + 1;

    logic [1:0]                full;
    logic                      wr_sel;
    logic                      rd_sel;
    logic [POINT_FFT_POW2-1:0] rd_cnt;
    logic [POINT_FFT_POW2-1:0] rd_addr;
    logic                      cap;
    logic                      out_valid;
    logic                      at_last;
    logic                      beat;
    logic signed [DW-1:0]      bank_re [2];
    logic signed [DW-1:0]      bank_im [2];

    always_comb begin
        cap       = bus.frame_valid_i && !full[wr_sel];
        out_valid = full[rd_sel];
        at_last   = (rd_cnt == POINT_FFT_POW2'(POINT_FFT - 1));
        beat      = out_valid && bus.bin_ready_i;
        rd_addr   = POINT_FFT_POW2'(bitrev(32'(rd_cnt), POINT_FFT_POW2));
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_frame_bank #(
            .AW (POINT_FFT_POW2),
            .DW (DW)
        ) u_bank (
            .clk_i     (clk_i),
            .we_i      (cap && (wr_sel == 1'(b))),
            .wr_re_i   (bus.frame_i[0]),
            .wr_im_i   (bus.frame_i[1]),
            .rd_addr_i (rd_addr),
            .rd_re_o   (bank_re[b]),
            .rd_im_o   (bank_im[b])
        );
    end

    // A capture and a final-beat release never target the same bank: capture needs
    // full[wr_sel]=0 while a beat needs full[rd_sel]=1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full   <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            rd_cnt <= '0;
        end else begin
            if (cap) begin
                full[wr_sel] <= 1'b1;
                wr_sel       <= !wr_sel;
            end
            if (beat) begin
                if (at_last) begin
                    rd_cnt       <= '0;
                    full[rd_sel] <= 1'b0;
                    rd_sel       <= !rd_sel;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.frame_ready_o = !full[wr_sel];
        bus.bin_valid_o   = out_valid;
        bus.bin_re_o      = out_valid ? bank_re[rd_sel] : '0;
        bus.bin_im_o      = out_valid ? bank_im[rd_sel] : '0;
        bus.bin_last_o    = out_valid && at_last;
`ifdef FFT_BIN_IDX_EN
        bus.bin_idx_o     = out_valid ? rd_cnt : '0;
`endif
    end

endmodule

// File: tb/tb_fft_bitrev_streamer.sv
// Scoreboard bench for fft_bitrev_streamer; bin index is also checked when FFT_BIN_IDX_EN is defined.
module tb_fft_bitrev_streamer;
    import fft_pkg::*;

    localparam int N = 16;

    typedef struct {
        int re;
        int im;
        bit last;
        int idx;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic bp_en = 1'b0;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   beats  = 0;
    int   last_beat_cyc = 0;
    exp_t sb[$];
    int   order[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_bitrev_streamer_if #(.POINT_FFT_POW2(4), .FRAC_BITS(15)) bus ();

    fft_bitrev_streamer #(.POINT_FFT_POW2(4), .FRAC_BITS(15)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input int base);
        for (int k = 0; k < N; k++) begin
            sb.push_back('{re: base + order[k], im: -(base + order[k]), last: (k == N - 1), idx: k});
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the capturing edge.
    task automatic send(input int base, output int cap_cyc, output int stalls);
        for (int p = 0; p < N; p++) begin
            bus.frame_i[0][p] = DW_DFLT'(base + p);
            bus.frame_i[1][p] = DW_DFLT'(-(base + p));
        end
        bus.frame_valid_i = 1'b1;
        stalls  = 0;
        cap_cyc = -1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (bus.frame_ready_o) begin
                cap_cyc = cyc + 1;
                @(posedge clk);
                push_frame(base);
                #1;
                bus.frame_valid_i = 1'b0;
                return;
            end
            stalls++;
        end
        chk("frame_accept_timeout", 0, 1);
        bus.frame_valid_i = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (bp_en) begin
            #1;
            bus.bin_ready_i = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops on every accepted beat, checks hold under backpressure and idle zeros.
    cplx_t held_v;
    bit    held_last;
    bit    held = 1'b0;
    exp_t  e;

    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else if (bus.bin_valid_o) begin
            if (held) begin
                chk("hold_re", int'(bus.bin_re_o), int'(held_v.re));
                chk("hold_im", int'(bus.bin_im_o), int'(held_v.im));
                chk("hold_last", int'(bus.bin_last_o), int'(held_last));
            end
            if (bus.bin_ready_i) begin
                held = 1'b0;
                beats++;
                last_beat_cyc = cyc + 1;
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("bin_re", int'(bus.bin_re_o), e.re);
                    chk("bin_im", int'(bus.bin_im_o), e.im);
                    chk("bin_last", int'(bus.bin_last_o), int'(e.last));
`ifdef FFT_BIN_IDX_EN
                    chk("bin_idx", int'(bus.bin_idx_o), e.idx);
`endif
                end
            end else begin
                held      = 1'b1;
                held_v.re = bus.bin_re_o;
                held_v.im = bus.bin_im_o;
                held_last = bus.bin_last_o;
            end
        end else begin
            if (held) chk("valid_dropped_under_backpressure", 0, 1);
            held = 1'b0;
            chk("idle_re", int'(bus.bin_re_o), 0);
            chk("idle_im", int'(bus.bin_im_o), 0);
            chk("idle_last", int'(bus.bin_last_o), 0);
`ifdef FFT_BIN_IDX_EN
            chk("idle_idx", int'(bus.bin_idx_o), 0);
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int ca, cb, cc, st, b0, t;
        bus.frame_valid_i = 1'b0;
        bus.bin_ready_i   = 1'b0;
        for (int p = 0; p < N; p++) begin
            bus.frame_i[0][p] = '0;
            bus.frame_i[1][p] = '0;
        end

        // Reset state
        #2 rst_n = 1'b0;
        #10;
        chk("rst_frame_ready", int'(bus.frame_ready_o), 1);
        chk("rst_bin_valid", int'(bus.bin_valid_o), 0);
        chk("rst_bin_last", int'(bus.bin_last_o), 0);
        chk("rst_bin_re", int'(bus.bin_re_o), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single frame, ready held high
        bus.bin_ready_i = 1'b1;
        send(0, ca, st);
        chk("valid_one_cycle_after_capture", int'(bus.bin_valid_o), 1);
        drain();

        // Pseudo-random backpressure
        bp_en = 1'b1;
        send(1000, ca, st);
        drain();
        bp_en = 1'b0;
        @(posedge clk); #1;
        bus.bin_ready_i = 1'b1;
        @(posedge clk); #1;

        // Back-to-back A, B, C
        b0 = beats;
        send(0, ca, st);
        send(100, cb, st);
        chk("b_captured_next_cycle", cb - ca, 1);
        send(200, cc, st);
        chk("c_stalled_while_both_full", st, 15);
        chk("c_captured_after_a_last", cc - ca, 17);
        drain();
        chk("b2b_beat_count", beats - b0, 48);
        chk("b2b_no_bubbles", last_beat_cyc - ca, 48);

        // Sink stalled with three frames offered
        bus.bin_ready_i = 1'b0;
        send(300, ca, st);
        send(400, cb, st);
        fork
            send(500, cc, st);
            begin
                repeat (10) begin
                    @(negedge clk);
                    chk("ready_low_both_full", int'(bus.frame_ready_o), 0);
                end
                @(posedge clk); #1;
                bus.bin_ready_i = 1'b1;
            end
        join
        drain();

        // Reset mid-frame after the fifth beat
        b0 = beats;
        send(600, ca, st);
        t = 0;
        while (beats < b0 + 5 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("five_beats_before_reset", beats - b0, 5);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_bin_valid", int'(bus.bin_valid_o), 0);
        chk("midrst_frame_ready", int'(bus.frame_ready_o), 1);
        chk("midrst_bin_re", int'(bus.bin_re_o), 0);
        chk("midrst_bin_im", int'(bus.bin_im_o), 0);
        chk("midrst_bin_last", int'(bus.bin_last_o), 0);
        sb.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send(700, ca, st);
        chk("post_reset_valid_after_capture", int'(bus.bin_valid_o), 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
